// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared single-port data memory (CPU port 0, debug port 1).
// Define DMEM_ARB_FIXED_PRIO_EN to give port 0 every tie; otherwise ties alternate round-robin.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [31:0]       addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              cpu_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned REQ_ADDR_W = 32;
    localparam int unsigned STATE_W    = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

    logic [STATE_W-1:0] state_q, state_d;
    logic               id_q, id_d;
    logic               we_q, we_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               win_c;
    logic               in_done_c;
    logic               unused_addr_c;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic               last_q, last_d;
`endif

    // Upper request address bits are don't-care: the memory only has 2**ADDR_W words.
    assign unused_addr_c = ^{addr0[REQ_ADDR_W-1:ADDR_W], addr1[REQ_ADDR_W-1:ADDR_W]};

    // Winner select: 0 = CPU port, 1 = debug port.
    always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        win_c = ~req0;
`else
        win_c = (req0 & req1) ? ~last_q : ~req0;
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    state_d     = ST_ISSUE;
                    id_d        = win_c;
                    we_d        = win_c ? we1 : we0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = win_c ? we1 : we0;
                    mem_addr_d  = win_c ? addr1[ADDR_W-1:0] : addr0[ADDR_W-1:0];
                    mem_wdata_d = win_c ? wdata1 : wdata0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                last_d  = id_q;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Pointer starts at port 1 so the first tie after reset goes to the CPU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign in_done_c = (state_q == ST_DONE);
    assign ack0      = in_done_c & ~id_q;
    assign ack1      = in_done_c & id_q;
    assign rdata     = (in_done_c & ~we_q) ? mem_rdata : '0;
    assign cpu_stall = req0 & ~ack0;

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level grant model plus a 256-word memory behind the DUT.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, cpu_stall, mem_en, mem_we;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] dmem    [256];
    logic [31:0] ref_mem [256];

    // Model: one grant record; a grant sampled at edge E has mem_en in cycle E, ack in E+1.
    int          m_cyc, m_next, g_edge;
    bit          m_last, g_id, g_we;
    logic [7:0]  g_addr;
    logic [31:0] g_wd;

    int          en_count = 0;
    logic [7:0]  last_en_addr;
    bit          last_en_we;
    logic [31:0] last_rdata;
    bit          ack_log[$];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .cpu_stall(cpu_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dmem[mem_addr] <= mem_wdata;
            else        mem_rdata      <= dmem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pick(input bit r0, input bit r1, input bit last);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        return !r0;
`else
        if (r0 && r1) return !last;
        return !r0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        if (!rst_n) begin
            m_cyc  <= 0;
            m_next <= 1;
            g_edge <= -10;
            m_last <= 1'b1;
        end else begin
            if (g_edge + 1 == m_cyc + 1 && g_we) ref_mem[g_addr] <= g_wd;
            if (m_cyc + 1 >= m_next && (req0 || req1)) begin
                g_edge <= m_cyc + 1;
                m_next <= m_cyc + 4;
                g_id   <= pick(req0, req1, m_last);
                m_last <= pick(req0, req1, m_last);
                g_we   <= pick(req0, req1, m_last) ? we1 : we0;
                g_addr <= pick(req0, req1, m_last) ? addr1[7:0] : addr0[7:0];
                g_wd   <= pick(req0, req1, m_last) ? wdata1 : wdata0;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin : cmp
        bit e_en, e_a0, e_a1;
        if (rst_n) begin
            e_en = (g_edge == m_cyc);
            e_a0 = (g_edge + 1 == m_cyc) && !g_id;
            e_a1 = (g_edge + 1 == m_cyc) && g_id;
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("mem_we", 32'(mem_we), 32'(e_en && g_we));
            if (e_en) begin
                chk("mem_addr", 32'(mem_addr), 32'(g_addr));
                if (g_we) chk("mem_wdata", mem_wdata, g_wd);
            end
            chk("ack0", 32'(ack0), 32'(e_a0));
            chk("ack1", 32'(ack1), 32'(e_a1));
            chk("cpu_stall", 32'(cpu_stall), 32'(req0 && !e_a0));
            if (e_a0 || e_a1) chk("rdata", rdata, g_we ? 32'h0 : ref_mem[g_addr]);
            if (mem_en) begin
                en_count++;
                last_en_addr = mem_addr;
                last_en_we   = mem_we;
            end
            if (ack0 || ack1) begin
                last_rdata = rdata;
                ack_log.push_back(ack1);
            end
        end
    end

    // Starts just after a rising edge, holds the request until its ack, ends just after a rising edge.
    task automatic access(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wd);
        bit got = 0;
        if (!port) begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
        else       begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if ((!port && ack0) || (port && ack1)) got = 1;
        end
        n_vec++;
        if (!got) begin
            n_bad++;
            $display("FAIL ack_timeout: port %0d got no ack, expected ack within 20 cycles", port);
        end
        @(posedge clk); #1;
        if (!port) req0 = 0; else req1 = 0;
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem_rdata = '0;
        req0 = 1; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_ack0", 32'(ack0), 32'd0);
        chk("rst_ack1", 32'(ack1), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall_hi", 32'(cpu_stall), 32'd1);
        req0 = 0;
        #1;
        chk("rst_stall_lo", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // CPU write then read back
        access(0, 1, 32'h10, 32'hDEADBEEF);
        chk("p0_wr_we", 32'(last_en_we), 32'd1);
        chk("p0_wr_addr", 32'(last_en_addr), 32'h10);
        access(0, 0, 32'h10, 32'h0);
        chk("p0_rd_data", last_rdata, 32'hDEADBEEF);

        // Debug write with upper address bits set, CPU reads the folded word
        access(1, 1, 32'h1FF, 32'h12345678);
        chk("p1_wr_addr", 32'(last_en_addr), 32'hFF);
        access(0, 0, 32'hFF, 32'h0);
        chk("p0_rd_ff", last_rdata, 32'h12345678);

        // Debug port drops and re-raises between requests: one memory access each
        n0 = en_count;
        access(1, 0, 32'h10, 32'h0);
        chk("p1_rd_10", last_rdata, 32'hDEADBEEF);
        repeat (2) @(posedge clk); #1;
        access(1, 0, 32'h3FF, 32'h0);
        chk("p1_rd_ff", last_rdata, 32'h12345678);
        chk("p1_en_count", 32'(en_count - n0), 32'd2);

        // Reset while a write is in ISSUE: abandoned, no memory update
        req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'hAAAA5555;
        @(posedge clk); #2;
        chk("mid_en_pre", 32'(mem_en), 32'd1);
        chk("mid_we_pre", 32'(mem_we), 32'd1);
        rst_n = 0;
        #1;
        chk("mid_en_rst", 32'(mem_en), 32'd0);
        chk("mid_we_rst", 32'(mem_we), 32'd0);
        chk("mid_ack0_rst", 32'(ack0), 32'd0);
        chk("mid_ack1_rst", 32'(ack1), 32'd0);
        req0 = 0; we0 = 0;
        repeat (2) @(negedge clk);
        chk("mid_mem_kept", dmem[8'h30], 32'h1000_0030);
        rst_n = 1;
        @(posedge clk); #1;

        // Both ports request continuously from reset
        ack_log.delete();
        req0 = 1; we0 = 0; addr0 = 32'h10;
        req1 = 1; we1 = 0; addr1 = 32'h20;
        repeat (12) @(posedge clk); #1;
        req0 = 0; req1 = 0;
        repeat (4) @(posedge clk); #1;
        chk("tie_count", 32'(ack_log.size()), 32'd4);
        if (ack_log.size() == 4) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            chk("tie_g0", 32'(ack_log[0]), 32'd0);
            chk("tie_g1", 32'(ack_log[1]), 32'd0);
            chk("tie_g2", 32'(ack_log[2]), 32'd0);
            chk("tie_g3", 32'(ack_log[3]), 32'd0);
`else
            chk("tie_g0", 32'(ack_log[0]), 32'd0);
            chk("tie_g1", 32'(ack_log[1]), 32'd1);
            chk("tie_g2", 32'(ack_log[2]), 32'd0);
            chk("tie_g3", 32'(ack_log[3]), 32'd1);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
